pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Hazard/sequencing controller for the 5-stage MIPS pipeline. Consumes the decoded register
//  fields of the ID, EX, MEM and WB stages and drives the pipeline control signals:
//  - EX-stage forwarding selects.
//  - Load-use stalls.
//  - Multi-cycle mult/div interlock.
//  - Taken-branch flushes.
//  Also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  MULDIV_LATENCY  32  cycles HI/LO stay busy after a mult/div issues; legal range 1..255
//  CNT_W           16  width of the stall-cycle counter
// PORTS
//  i_clk            in   1      clock, rising edge
//  i_reset          in   1      asynchronous reset, active-high
//  i_id_valid       in   1      ID stage holds a valid instruction
//  i_id_rs          in   5      ID source register rs
//  i_id_rt          in   5      ID source register rt
//  i_id_uses_rs     in   1      ID instruction reads rs
//  i_id_uses_rt     in   1      ID instruction reads rt
//  i_id_muldiv      in   1      ID instruction is mult/multu/div/divu
//  i_id_hilo_read   in   1      ID instruction is mfhi/mflo
//  i_ex_valid       in   1      EX stage holds a valid instruction
//  i_ex_rs          in   5      EX source register rs
//  i_ex_rt          in   5      EX source register rt
//  i_ex_rd          in   5      EX destination register
//  i_ex_mem_read    in   1      EX instruction is a load
//  i_ex_branch_taken in  1      branch/jump resolved taken in EX
//  i_mem_rd         in   5      MEM destination register
//  i_mem_reg_write  in   1      MEM instruction writes the register file
//  i_wb_rd          in   5      WB destination register
//  i_wb_reg_write   in   1      WB instruction writes the register file
//  o_fwd_a          out  2      ALU operand A source: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//  o_fwd_b          out  2      ALU operand B source: same encoding as o_fwd_a
//  o_pc_stall       out  1      hold the PC
//  o_ifid_stall     out  1      hold the IF/ID register
//  o_idex_bubble    out  1      insert a NOP into ID/EX
//  o_ifid_flush     out  1      clear IF/ID
//  o_idex_flush     out  1      clear ID/EX
//  o_muldiv_busy    out  1      HI/LO result pending (registered)
//  o_stall_cycles   out  CNT_W  saturating count of cycles with o_pc_stall = 1
// BEHAVIOUR
//  - Reset: FSM = MD_IDLE, mult/div counter = 0, o_stall_cycles = 0, o_muldiv_busy = 0.
//    While i_reset = 1, all combinational outputs are forced to 0.
//  - Forwarding (combinational; same rule for operand B using i_ex_rt):
//    fwd_a = 10 if i_mem_reg_write & i_mem_rd != 0 & i_mem_rd == i_ex_rs;
//    else 01 if i_wb_reg_write & i_wb_rd != 0 & i_wb_rd == i_ex_rs;
//    else 00. MEM takes priority over WB.
//  - Load-use (combinational): lu = i_id_valid & i_ex_valid & i_ex_mem_read & i_ex_rd != 0 &
//    ((i_id_uses_rs & i_ex_rd == i_id_rs) | (i_id_uses_rt & i_ex_rd == i_id_rt)).
//  - HI/LO interlock: hl = i_id_valid & o_muldiv_busy & (i_id_muldiv | i_id_hilo_read).
//  - stall = (lu | hl) & ~i_ex_branch_taken. stall drives o_pc_stall, o_ifid_stall and
//    o_idex_bubble, all asserted in the same cycle.
//  - Branch: i_ex_branch_taken = 1 -> o_ifid_flush = 1 and o_idex_flush = 1 that cycle.
//    A flush overrides any stall: all stall outputs are 0 in that cycle.
//  - Issue: issue = i_id_valid & i_id_muldiv & ~stall & ~i_ex_branch_taken.
//  - FSM MD_IDLE -> MD_BUSY on issue: counter <= MULDIV_LATENCY.
//  - In MD_BUSY the counter decrements every cycle. When counter == 1 it goes to 0 and the
//    FSM returns to MD_IDLE.
//  - o_muldiv_busy = (state == MD_BUSY).
//  - Timing: issue in cycle N -> o_muldiv_busy = 1 in cycles N+1 .. N+MULDIV_LATENCY,
//    0 in cycle N+MULDIV_LATENCY+1. A waiting mfhi is released in that cycle.
//  - A second mult/div cannot issue while busy: hl stalls it.
//  - A branch flush does not cancel an already-running count.
//  - o_stall_cycles increments on each cycle with o_pc_stall = 1 and holds at 2^CNT_W-1.
//  - Asynchronous reset mid-count clears the FSM, counter and o_stall_cycles immediately.
// TESTING
//  1. i_mem_rd=5/write=1, i_wb_rd=5/write=1, i_ex_rs=5 -> o_fwd_a=10; clear MEM write ->
//     o_fwd_a=01; all rd=0 -> o_fwd_a=00.
//  2. i_ex_mem_read=1, i_ex_rd=8, i_id_rs=8, i_id_uses_rs=1 -> stall and bubble for exactly
//     1 cycle; repeat with i_id_uses_rs=0 -> no stall.
//  3. MULDIV_LATENCY=4: mult issues in cycle 10, mfhi in ID in cycle 11 -> o_muldiv_busy and
//     stall in cycles 11-14; mfhi proceeds in cycle 15.
//  4. Load-use and i_ex_branch_taken=1 in the same cycle -> both flushes = 1, stalls = 0.
//     Branch taken together with a mult in ID -> o_muldiv_busy stays 0.
//  5. i_reset pulsed while counter = 2 -> o_muldiv_busy = 0 and o_stall_cycles = 0 at once.
//     A pending mfhi is not stalled after reset releases.
//  6. CNT_W=4, 20 consecutive stall cycles -> o_stall_cycles = 15 and holds there.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: stage register fields in, pipeline control signals out
interface pipeline_hazard_controller_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_muldiv;
  logic             id_hilo_read;
  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv, id_hilo_read,
           ex_valid, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  fwd_a, fwd_b, pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           muldiv_busy, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv, id_hilo_read,
           ex_valid, ex_rs, ex_rt, ex_rd, ex_mem_read, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output fwd_a, fwd_b, pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
           muldiv_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: forwarding, load-use/HI-LO stalls, branch flushes, stall counter
module pipeline_hazard_controller #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 16
) (
  input logic i_clk,
  input logic i_reset,
  pipeline_hazard_controller_if.slave hz
);
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  md_state_t        state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       fwd_a, fwd_b;
  logic             lu, hl, stall, br, issue;
  assign fwd_a = (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs) ? 2'b10 :
                 (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs) ? 2'b01 : 2'b00;
  assign fwd_b = (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rt) ? 2'b10 :
                 (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rt) ? 2'b01 : 2'b00;
  assign lu    = hz.id_valid && hz.ex_valid && hz.ex_mem_read && hz.ex_rd != 5'd0 &&
                 ((hz.id_uses_rs && hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && hz.ex_rd == hz.id_rt));
  assign hl    = hz.id_valid && (state == MD_BUSY) && (hz.id_muldiv || hz.id_hilo_read);
  assign br    = hz.ex_branch_taken;
  assign stall = (lu || hl) && !br;
  assign issue = hz.id_valid && hz.id_muldiv && !stall && !br;
  // HI/LO busy state and remaining-cycle counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= MD_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // Load the latency on issue, count down while busy, go idle after the last busy cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == MD_IDLE && issue) begin
      state_nx = MD_BUSY;
      cnt_nx   = 8'(MULDIV_LATENCY);
    end else if (state == MD_BUSY) begin
      cnt_nx   = cnt - 8'd1;
      state_nx = (cnt == 8'd1) ? MD_IDLE : MD_BUSY;
    end
  end
  // Drive the control outputs; combinational ones are held low during reset
  always_comb begin
    hz.fwd_a        = i_reset ? 2'b00 : fwd_a;
    hz.fwd_b        = i_reset ? 2'b00 : fwd_b;
    hz.pc_stall     = !i_reset && stall;
    hz.ifid_stall   = !i_reset && stall;
    hz.idex_bubble  = !i_reset && stall;
    hz.ifid_flush   = !i_reset && br;
    hz.idex_flush   = !i_reset && br;
    hz.muldiv_busy  = (state == MD_BUSY);
    hz.stall_cycles = stall_cnt;
  end
  // Saturating count of PC-stall cycles
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) stall_cnt <= '0;
    else if (hz.pc_stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
